// File: rtl/collision_scan_if.sv
// Handshake and data bundle between the collision scanner and its controller/mux.
// The scanner connects through the slave modport; the controller side uses master.
interface collision_scan_if #(
  parameter int DATAWIDTH_SELECTOR = 3,
  parameter int DATAWIDTH_DATA     = 8
);
  logic                          CollisionScan_Start_In;
  logic                          CollisionScan_Abort_In;
  logic [DATAWIDTH_DATA-1:0]     CollisionScan_FrogMask_Bus_In;
  logic                          CollisionScan_MuxBit_In;
  logic [DATAWIDTH_SELECTOR-1:0] CollisionScan_Select_Bus_Out;
  logic                          CollisionScan_Busy_Out;
  logic                          CollisionScan_Done_Out;
  logic                          CollisionScan_Collision_Out;
  logic [DATAWIDTH_SELECTOR:0]   CollisionScan_ObstacleCount_Bus_Out;

  modport master (
    output CollisionScan_Start_In,
    output CollisionScan_Abort_In,
    output CollisionScan_FrogMask_Bus_In,
    output CollisionScan_MuxBit_In,
    input  CollisionScan_Select_Bus_Out,
    input  CollisionScan_Busy_Out,
    input  CollisionScan_Done_Out,
    input  CollisionScan_Collision_Out,
    input  CollisionScan_ObstacleCount_Bus_Out
  );

  modport slave (
    input  CollisionScan_Start_In,
    input  CollisionScan_Abort_In,
    input  CollisionScan_FrogMask_Bus_In,
    input  CollisionScan_MuxBit_In,
    output CollisionScan_Select_Bus_Out,
    output CollisionScan_Busy_Out,
    output CollisionScan_Done_Out,
    output CollisionScan_Collision_Out,
    output CollisionScan_ObstacleCount_Bus_Out
  );
endinterface

// File: rtl/collision_scan.sv
// Walks an external bit mux across one row, counting obstacle bits and flagging
// any column where an obstacle overlaps the frog mask latched at start.
module collision_scan #(
  parameter int DATAWIDTH_SELECTOR = 3,
  parameter int DATAWIDTH_DATA     = 8
) (
  input  logic             CollisionScan_CLOCK_50,
  input  logic             CollisionScan_RESET_InHigh,
  collision_scan_if.slave  bus_if
);

  localparam int SW = DATAWIDTH_SELECTOR;
  localparam logic [SW-1:0] SEL_LAST = SW'(DATAWIDTH_DATA - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [SW-1:0]             sel_q, sel_d;
  logic [DATAWIDTH_DATA-1:0] mask_q, mask_d;
  logic                      hit_q, hit_d;
  logic [SW:0]               cnt_q, cnt_d;
  logic                      coll_q, coll_d;
  logic [SW:0]               ocnt_q, ocnt_d;

  logic                      sample_hit;
  logic [SW:0]               cnt_next;

  assign sample_hit = bus_if.CollisionScan_MuxBit_In & mask_q[sel_q];
  assign cnt_next   = cnt_q + {{SW{1'b0}}, bus_if.CollisionScan_MuxBit_In};

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    hit_d   = hit_q;
    cnt_d   = cnt_q;
    coll_d  = coll_q;
    ocnt_d  = ocnt_q;
    case (state_q)
      IDLE: begin
        if (bus_if.CollisionScan_Start_In && !bus_if.CollisionScan_Abort_In) begin
          state_d = SCAN;
          sel_d   = '0;
          mask_d  = bus_if.CollisionScan_FrogMask_Bus_In;
          hit_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (bus_if.CollisionScan_Abort_In) begin
          state_d = IDLE;
          sel_d   = '0;
        end else begin
          hit_d = hit_q | sample_hit;
          cnt_d = cnt_next;
          // Last column: publish results including this sample, keep select parked.
          if (sel_q == SEL_LAST) begin
            state_d = DONE;
            coll_d  = hit_q | sample_hit;
            ocnt_d  = cnt_next;
          end else begin
            sel_d = sel_q + SW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        sel_d   = '0;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CollisionScan_CLOCK_50) begin
    if (CollisionScan_RESET_InHigh) begin
      state_q <= IDLE;
      sel_q   <= '0;
      mask_q  <= '0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      coll_q  <= 1'b0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      coll_q  <= coll_d;
      ocnt_q  <= ocnt_d;
    end
  end

  assign bus_if.CollisionScan_Select_Bus_Out        = sel_q;
  assign bus_if.CollisionScan_Busy_Out              = (state_q == SCAN);
  assign bus_if.CollisionScan_Done_Out              = (state_q == DONE);
  assign bus_if.CollisionScan_Collision_Out         = coll_q;
  assign bus_if.CollisionScan_ObstacleCount_Bus_Out = ocnt_q;

endmodule

// File: tb/tb_collision_scan.sv
// Bench for collision_scan: table vectors, multi-cycle corner sequences and
// random rows/masks checked against a row-level arithmetic model.
module tb_collision_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] row_r = 8'h00;

  int checks = 0;
  int errors = 0;

  collision_scan_if #(.DATAWIDTH_SELECTOR(3), .DATAWIDTH_DATA(8)) bus ();

  assign bus.CollisionScan_MuxBit_In = row_r[bus.CollisionScan_Select_Bus_Out];

  collision_scan #(.DATAWIDTH_SELECTOR(3), .DATAWIDTH_DATA(8)) dut (
    .CollisionScan_CLOCK_50     (clk),
    .CollisionScan_RESET_InHigh (rst),
    .bus_if                     (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] row;
    logic [7:0] mask;
    logic       exp_coll;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_coll(input logic [7:0] row, input logic [7:0] mask);
    return (row & mask) != 8'h00;
  endfunction

  function automatic logic [3:0] model_cnt(input logic [7:0] row);
    int n = 0;
    for (int i = 0; i < 8; i++) n += row[i] ? 1 : 0;
    return 4'(n);
  endfunction

  // Full scan from IDLE; optional mask change / start re-pulse / abort during DONE.
  task automatic run_scan(input string tag, input logic [7:0] row, input logic [7:0] mask,
                          input logic exp_coll, input logic [3:0] exp_cnt,
                          input int chg_cyc, input logic [7:0] chg_mask,
                          input int restart_cyc, input logic abort_in_done);
    row_r = row;
    bus.CollisionScan_FrogMask_Bus_In = mask;
    bus.CollisionScan_Start_In = 1'b1;
    tick();
    bus.CollisionScan_Start_In = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == chg_cyc) bus.CollisionScan_FrogMask_Bus_In = chg_mask;
      bus.CollisionScan_Start_In = (c == restart_cyc);
      chk({tag, " select"}, 32'(bus.CollisionScan_Select_Bus_Out), 32'(c - 1));
      chk({tag, " busy"}, 32'(bus.CollisionScan_Busy_Out), 32'd1);
      chk({tag, " done_early"}, 32'(bus.CollisionScan_Done_Out), 32'd0);
      tick();
    end
    bus.CollisionScan_Start_In = 1'b0;
    bus.CollisionScan_Abort_In = abort_in_done;
    chk({tag, " done"}, 32'(bus.CollisionScan_Done_Out), 32'd1);
    chk({tag, " busy_done"}, 32'(bus.CollisionScan_Busy_Out), 32'd0);
    chk({tag, " select_held"}, 32'(bus.CollisionScan_Select_Bus_Out), 32'd7);
    chk({tag, " collision"}, 32'(bus.CollisionScan_Collision_Out), 32'(exp_coll));
    chk({tag, " count"}, 32'(bus.CollisionScan_ObstacleCount_Bus_Out), 32'(exp_cnt));
    tick();
    bus.CollisionScan_Abort_In = 1'b0;
    chk({tag, " done_one_cycle"}, 32'(bus.CollisionScan_Done_Out), 32'd0);
    chk({tag, " busy_after"}, 32'(bus.CollisionScan_Busy_Out), 32'd0);
    chk({tag, " select_zero"}, 32'(bus.CollisionScan_Select_Bus_Out), 32'd0);
    chk({tag, " collision_kept"}, 32'(bus.CollisionScan_Collision_Out), 32'(exp_coll));
    chk({tag, " count_kept"}, 32'(bus.CollisionScan_ObstacleCount_Bus_Out), 32'(exp_cnt));
  endtask

  initial begin
    logic [7:0] r, m;

    vecs[0] = '{8'b0001_0000, 8'b0001_0000, 1'b1, 4'd1};
    vecs[1] = '{8'b1110_0000, 8'b0000_0011, 1'b0, 4'd3};
    vecs[2] = '{8'hFF,        8'h80,        1'b1, 4'd8};
    vecs[3] = '{8'h00,        8'hFF,        1'b0, 4'd0};
    vecs[4] = '{8'hFF,        8'h00,        1'b0, 4'd8};
    vecs[5] = '{8'h01,        8'h01,        1'b1, 4'd1};
    vecs[6] = '{8'h81,        8'h7E,        1'b0, 4'd2};
    vecs[7] = '{8'h80,        8'hC0,        1'b1, 4'd1};

    bus.CollisionScan_Start_In = 1'b0;
    bus.CollisionScan_Abort_In = 1'b0;
    bus.CollisionScan_FrogMask_Bus_In = 8'h00;

    // Reset, with start asserted to show reset overrides it.
    rst = 1'b1;
    bus.CollisionScan_Start_In = 1'b1;
    tick();
    tick();
    bus.CollisionScan_Start_In = 1'b0;
    rst = 1'b0;
    chk("reset select", 32'(bus.CollisionScan_Select_Bus_Out), 32'd0);
    chk("reset busy", 32'(bus.CollisionScan_Busy_Out), 32'd0);
    chk("reset done", 32'(bus.CollisionScan_Done_Out), 32'd0);
    chk("reset collision", 32'(bus.CollisionScan_Collision_Out), 32'd0);
    chk("reset count", 32'(bus.CollisionScan_ObstacleCount_Bus_Out), 32'd0);
    tick();
    chk("idle hold busy", 32'(bus.CollisionScan_Busy_Out), 32'd0);

    for (int i = 0; i < 8; i++)
      run_scan($sformatf("vec%0d", i), vecs[i].row, vecs[i].mask,
               vecs[i].exp_coll, vecs[i].exp_cnt, -1, 8'h00, -1, 1'b0);

    // Mask dropped to zero mid-scan: latched mask must still produce a hit.
    run_scan("mask_latch", 8'h08, 8'h08, 1'b1, 4'd1, 3, 8'h00, -1, 1'b0);
    // Start re-pulsed during SCAN is ignored; abort during DONE is ignored.
    run_scan("restart_ignored", 8'h3C, 8'h04, 1'b1, 4'd4, -1, 8'h00, 5, 1'b0);
    run_scan("abort_in_done", 8'h03, 8'h02, 1'b1, 4'd2, -1, 8'h00, -1, 1'b1);

    // Abort at cycle 4 of a new scan: prior results (1/2) retained.
    row_r = 8'hF0;
    bus.CollisionScan_FrogMask_Bus_In = 8'hF0;
    bus.CollisionScan_Start_In = 1'b1;
    tick();
    bus.CollisionScan_Start_In = 1'b0;
    tick(); tick(); tick();
    chk("abort pre busy", 32'(bus.CollisionScan_Busy_Out), 32'd1);
    bus.CollisionScan_Abort_In = 1'b1;
    tick();
    bus.CollisionScan_Abort_In = 1'b0;
    chk("abort busy", 32'(bus.CollisionScan_Busy_Out), 32'd0);
    chk("abort select", 32'(bus.CollisionScan_Select_Bus_Out), 32'd0);
    chk("abort collision", 32'(bus.CollisionScan_Collision_Out), 32'd1);
    chk("abort count", 32'(bus.CollisionScan_ObstacleCount_Bus_Out), 32'd2);
    for (int c = 0; c < 6; c++) begin
      chk("abort no_done", 32'(bus.CollisionScan_Done_Out), 32'd0);
      tick();
    end
    chk("abort idle busy", 32'(bus.CollisionScan_Busy_Out), 32'd0);
    chk("abort idle count", 32'(bus.CollisionScan_ObstacleCount_Bus_Out), 32'd2);

    // Abort and start together in IDLE: abort wins.
    bus.CollisionScan_Start_In = 1'b1;
    bus.CollisionScan_Abort_In = 1'b1;
    tick();
    bus.CollisionScan_Start_In = 1'b0;
    bus.CollisionScan_Abort_In = 1'b0;
    chk("start_abort busy", 32'(bus.CollisionScan_Busy_Out), 32'd0);
    chk("start_abort select", 32'(bus.CollisionScan_Select_Bus_Out), 32'd0);
    tick();
    chk("start_abort busy2", 32'(bus.CollisionScan_Busy_Out), 32'd0);
    chk("start_abort done", 32'(bus.CollisionScan_Done_Out), 32'd0);

    // Reset at cycle 6 of a scan: everything clears, no done, no auto restart.
    row_r = 8'hFF;
    bus.CollisionScan_FrogMask_Bus_In = 8'hFF;
    bus.CollisionScan_Start_In = 1'b1;
    tick();
    bus.CollisionScan_Start_In = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    chk("rst_mid pre select", 32'(bus.CollisionScan_Select_Bus_Out), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid select", 32'(bus.CollisionScan_Select_Bus_Out), 32'd0);
    chk("rst_mid busy", 32'(bus.CollisionScan_Busy_Out), 32'd0);
    chk("rst_mid done", 32'(bus.CollisionScan_Done_Out), 32'd0);
    chk("rst_mid collision", 32'(bus.CollisionScan_Collision_Out), 32'd0);
    chk("rst_mid count", 32'(bus.CollisionScan_ObstacleCount_Bus_Out), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst_mid stays idle", 32'({bus.CollisionScan_Busy_Out, bus.CollisionScan_Done_Out}), 32'd0);
    end

    // Random rows and masks against the row-level model.
    for (int i = 0; i < 25; i++) begin
      r = 8'($urandom);
      m = 8'($urandom);
      if (i % 5 == 0) m = r & ~(r - 8'd1);
      run_scan($sformatf("rand%0d", i), r, m, model_coll(r, m), model_cnt(r),
               -1, 8'h00, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_scan.md
COLLISION_SCAN -- requirements
Module: collision_scan

Interface
REQ-001 Parameter DATAWIDTH_SELECTOR, default 3, SHALL set the column-select width driven to the downstream 8:1 bit mux.
REQ-002 Parameter DATAWIDTH_DATA, default 8, SHALL set the number of row columns scanned and the frog-mask width; it SHALL equal 2**DATAWIDTH_SELECTOR.
REQ-003 CollisionScan_CLOCK_50  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 CollisionScan_RESET_InHigh  input  1  SHALL be a synchronous, active-high reset.
REQ-005 CollisionScan_Start_In  input  1  SHALL be a one-cycle start-of-scan request, honoured only in IDLE.
REQ-006 CollisionScan_Abort_In  input  1  SHALL cancel an in-progress scan.
REQ-007 CollisionScan_FrogMask_Bus_In  input  DATAWIDTH_DATA  SHALL give the frog's column occupancy in the current row (bit i = column i).
REQ-008 CollisionScan_MuxBit_In  input  1  SHALL be the obstacle bit returned combinationally by the mux for the currently driven select.
REQ-009 CollisionScan_Select_Bus_Out  output  DATAWIDTH_SELECTOR  SHALL drive the mux select (registered).
REQ-010 CollisionScan_Busy_Out  output  1  SHALL be high while in SCAN.
REQ-011 CollisionScan_Done_Out  output  1  SHALL pulse high for exactly one cycle when a scan completes.
REQ-012 CollisionScan_Collision_Out  output  1  SHALL flag that at least one column has both the obstacle bit and the frog-mask bit set.
REQ-013 CollisionScan_ObstacleCount_Bus_Out  output  DATAWIDTH_SELECTOR+1  SHALL give the number of obstacle bits equal to 1 in the last completed scan.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SCAN, DONE.
REQ-015 IDLE with Start_In=1 and Abort_In=0: next state SCAN; Select<=0; FrogMask latched into an internal register; internal hit flag and count cleared.
REQ-016 IDLE with Start_In=0: state, Select, Collision_Out and ObstacleCount_Out SHALL hold.
REQ-017 In SCAN, each cycle SHALL sample MuxBit_In for the current Select; count += MuxBit_In; hit |= MuxBit_In & latchedMask[Select].
REQ-018 In SCAN with Select < DATAWIDTH_DATA-1, Select SHALL increment by 1.
REQ-019 In SCAN with Select = DATAWIDTH_DATA-1, the sample SHALL be taken, next state DONE, Select SHALL hold at DATAWIDTH_DATA-1 (no wrap to 0).
REQ-020 On entering DONE, Collision_Out and ObstacleCount_Out SHALL update from the final hit/count including the last column; Done_Out=1 during DONE.
REQ-021 DONE SHALL always go to IDLE after one cycle; Select SHALL then return to 0.
REQ-022 Latency: Start sampled at cycle 0 -> SCAN occupies cycles 1..8 (selects 0..7) -> Done_Out high at cycle 9.
REQ-023 Start_In during SCAN or DONE SHALL be ignored (no restart, no queuing).
REQ-024 Changes to FrogMask_Bus_In after the start cycle SHALL NOT affect the scan in progress.
REQ-025 Abort_In=1 in SCAN SHALL force IDLE next cycle, Select<=0, no Done_Out pulse, Collision_Out and ObstacleCount_Out keep their previous completed-scan values.
REQ-026 Abort_In and Start_In both high in IDLE: Abort SHALL win; scan not started.
REQ-027 Abort_In in DONE SHALL be ignored; the completed results stand.
REQ-028 ObstacleCount SHALL count 0..DATAWIDTH_DATA without overflow (width DATAWIDTH_SELECTOR+1).

Reset
REQ-029 Reset SHALL be sampled only on the clock edge and SHALL override Start_In and Abort_In.
REQ-030 Reset SHALL force IDLE, Select_Out=0, Busy_Out=0, Done_Out=0, Collision_Out=0, ObstacleCount_Out=0, internal mask/hit/count=0.
REQ-031 Reset asserted mid-SCAN SHALL abandon the scan with no Done_Out pulse; the next scan SHALL require a new Start_In.

Verification
REQ-032 Row obstacles 8'b0001_0000, frog mask 8'b0001_0000, start pulse -> Select steps 0..7 on cycles 1..8, Done_Out=1 on cycle 9 only, Collision_Out=1, ObstacleCount=1.
REQ-033 Row 8'b1110_0000, mask 8'b0000_0011 -> Collision_Out=0, ObstacleCount=3; then row 8'hFF, mask 8'h80 -> Collision_Out=1, ObstacleCount=8.
REQ-034 Mask 8'h08 at start, changed to 8'h00 at cycle 3, row 8'h08 -> Collision_Out=1 (latched mask used).
REQ-035 After a scan giving Collision=1/Count=2, new scan aborted at cycle 4 -> returns to IDLE cycle 5, no Done pulse, Collision_Out=1 and Count=2 retained.
REQ-036 Start pulsed again at cycle 5 during SCAN -> ignored, Done still at cycle 9 only; reset at cycle 6 of a scan -> all outputs 0 next cycle, no Done pulse.
